// File: rtl/conv_sched_pkg.sv
// Shared types and constants for the conv_11 frame scheduler.
package conv_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [31:0] FP_ONE = 32'h3f80_0000;

  // Counter width able to hold 0..t inclusive (t = pixels per channel).
  function automatic int idx_width(input int t);
    return $clog2(t + 1);
  endfunction

endpackage

// File: rtl/conv_kernel_bank.sv
// Per-channel kernel register file; writable only while idle, read out on a load strobe.
module conv_kernel_bank
  import conv_sched_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int unsigned CH         = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  idle,
  input  logic                  wr_en,
  input  logic [1:0]            wr_sel,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  ld,
  input  logic [1:0]            ld_ch,
  output logic [DATA_WIDTH-1:0] kernel_out
);

  logic [DATA_WIDTH-1:0] regs_q [CH];
  logic [DATA_WIDTH-1:0] regs_d [CH];
  logic [DATA_WIDTH-1:0] kout_q;
  logic [DATA_WIDTH-1:0] kout_d;

  always_comb begin
    regs_d = regs_q;
    kout_d = kout_q;
    if (idle && wr_en && ({30'd0, wr_sel} < CH)) begin
      regs_d[wr_sel] = wr_data;
    end else begin
      regs_d = regs_q;
    end
    // The output only moves on channel entry so conv_11 sees a stable kernel.
    if (ld) begin
      kout_d = regs_q[ld_ch];
    end else begin
      kout_d = kout_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(CH); i++) begin
        regs_q[i] <= DATA_WIDTH'(FP_ONE);
      end
      kout_q <= DATA_WIDTH'(FP_ONE);
    end else begin
      regs_q <= regs_d;
      kout_q <= kout_d;
    end
  end

  assign kernel_out = kout_q;

endmodule

// File: rtl/conv_frame_sched.sv
// Streams one CH-channel frame from image memory through conv_11 and forwards
// tagged results; drains conv_11 completely before moving to the next channel.
module conv_frame_sched
  import conv_sched_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          D          = 299,
  parameter int unsigned CH         = 3,
  parameter int          ADDR_W     = 19
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  hold,
  input  logic                  kw_en,
  input  logic [1:0]            kw_sel,
  input  logic [DATA_WIDTH-1:0] kw_data,
  output logic                  mem_rd_en,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  conv_valid_in,
  output logic [DATA_WIDTH-1:0] conv_pxl_in,
  output logic [DATA_WIDTH-1:0] conv_kernel_00,
  input  logic                  conv_valid_out,
  input  logic [DATA_WIDTH-1:0] conv_pxl_out,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_pxl,
  output logic [1:0]            out_ch,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int              T       = D * D;
  localparam int              IW      = idx_width(T);
  localparam logic [IW-1:0]   T_LAST  = IW'(T - 1);
  localparam logic [IW-1:0]   T_FULL  = IW'(T);
  localparam logic [1:0]      CH_LAST = 2'(CH - 1);
  localparam logic [ADDR_W-1:0] T_ADDR = ADDR_W'(T);

  state_e                state_q, state_d;
  logic [1:0]            ch_q, ch_d;
  logic [IW-1:0]         rd_idx_q, rd_idx_d;
  logic [IW-1:0]         out_idx_q, out_idx_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic                  conv_valid_in_q, conv_valid_in_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_pxl_q, out_pxl_d;
  logic [1:0]            out_ch_q, out_ch_d;
  logic                  out_last_q, out_last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  rd_en_s;
  logic                  kload_s;
  logic [1:0]            kch_s;
  logic                  fwd_ok_s;

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    rd_idx_d    = rd_idx_q;
    out_idx_d   = out_idx_q;
    base_d      = base_q;
    out_valid_d = 1'b0;
    out_pxl_d   = out_pxl_q;
    out_ch_d    = out_ch_q;
    out_last_d  = 1'b0;
    err_d       = err_q;
    rd_en_s     = 1'b0;
    kload_s     = 1'b0;
    kch_s       = ch_q;

    fwd_ok_s = conv_valid_out && ((state_q == S_ISSUE) || (state_q == S_DRAIN))
               && (out_idx_q < T_FULL);
    if (fwd_ok_s) begin
      out_valid_d = 1'b1;
      out_pxl_d   = conv_pxl_out;
      out_ch_d    = ch_q;
      out_last_d  = (ch_q == CH_LAST) && (out_idx_q == T_LAST);
      out_idx_d   = out_idx_q + {{(IW-1){1'b0}}, 1'b1};
    end else if (conv_valid_out) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_ISSUE;
          ch_d      = 2'd0;
          rd_idx_d  = '0;
          out_idx_d = '0;
          base_d    = '0;
          kload_s   = 1'b1;
          kch_s     = 2'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (!hold) begin
          rd_en_s  = 1'b1;
          rd_idx_d = rd_idx_q + {{(IW-1){1'b0}}, 1'b1};
          state_d  = (rd_idx_q == T_LAST) ? S_DRAIN : S_ISSUE;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_DRAIN: begin
        // Leave on the same cycle the final result of the channel is accepted.
        if (out_idx_d == T_FULL) begin
          if (ch_q == CH_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d   = S_ISSUE;
            ch_d      = ch_q + 2'd1;
            base_d    = base_q + T_ADDR;
            rd_idx_d  = '0;
            out_idx_d = '0;
            kload_s   = 1'b1;
            kch_s     = ch_q + 2'd1;
          end
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    conv_valid_in_d = rd_en_s;
    busy_d          = (state_d != S_IDLE);
    done_d          = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      ch_q            <= 2'd0;
      rd_idx_q        <= '0;
      out_idx_q       <= '0;
      base_q          <= '0;
      conv_valid_in_q <= 1'b0;
      out_valid_q     <= 1'b0;
      out_pxl_q       <= '0;
      out_ch_q        <= 2'd0;
      out_last_q      <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      ch_q            <= ch_d;
      rd_idx_q        <= rd_idx_d;
      out_idx_q       <= out_idx_d;
      base_q          <= base_d;
      conv_valid_in_q <= conv_valid_in_d;
      out_valid_q     <= out_valid_d;
      out_pxl_q       <= out_pxl_d;
      out_ch_q        <= out_ch_d;
      out_last_q      <= out_last_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      err_q           <= err_d;
    end
  end

  conv_kernel_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .CH         (CH)
  ) u_kernel_bank (
    .clk        (clk),
    .reset      (reset),
    .idle       (state_q == S_IDLE),
    .wr_en      (kw_en),
    .wr_sel     (kw_sel),
    .wr_data    (kw_data),
    .ld         (kload_s),
    .ld_ch      (kch_s),
    .kernel_out (conv_kernel_00)
  );

  // Reads follow hold in the same cycle; the address is zero when idle.
  assign mem_rd_en     = rd_en_s;
  assign mem_addr      = rd_en_s ? (base_q + ADDR_W'(rd_idx_q)) : '0;
  assign conv_valid_in = conv_valid_in_q;
  assign conv_pxl_in   = mem_rd_data;
  assign out_valid     = out_valid_q;
  assign out_pxl       = out_pxl_q;
  assign out_ch        = out_ch_q;
  assign out_last      = out_last_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: doc/conv_frame_sched.md
Name: conv_frame_sched

Overview:
- Sequences one full multi-channel frame through the conv_11 1x1 floating-point convolution datapath.
- Fetches pixels channel by channel from a synchronous-read image memory and streams them into conv_11.
- Selects the per-channel kernel word and drains conv_11 before switching channels.
- Forwards results tagged with channel and last markers; sits between the frame buffer and the result writer.

Parameters:
- DATA_WIDTH, 32, pixel/kernel word width (IEEE-754 single).
- D, 299, image side; pixels per channel T = D*D.
- CH, 3, channels per frame.
- ADDR_W, 19, memory address width; must satisfy 2^ADDR_W >= CH*T.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to process a frame.
- hold  in  1  pauses issue of new memory reads while high.
- kw_en  in  1  kernel register write strobe.
- kw_sel  in  2  kernel register index (0..CH-1).
- kw_data  in  DATA_WIDTH  kernel word to write.
- mem_rd_en  out  1  memory read strobe.
- mem_addr  out  ADDR_W  memory read address.
- mem_rd_data  in  DATA_WIDTH  read data, valid exactly 1 cycle after mem_rd_en.
- conv_valid_in  out  1  to conv_11 valid_in.
- conv_pxl_in  out  DATA_WIDTH  to conv_11 pxl_in.
- conv_kernel_00  out  DATA_WIDTH  to conv_11 kernel_00.
- conv_valid_out  in  1  from conv_11 valid_out.
- conv_pxl_out  in  DATA_WIDTH  from conv_11 pxl_out.
- out_valid  out  1  result valid.
- out_pxl  out  DATA_WIDTH  result pixel.
- out_ch  out  2  channel index of the result.
- out_last  out  1  high with the final result of the frame.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at frame completion.
- err  out  1  sticky flag for an unexpected conv_valid_out.

Behaviour:
- Reset (async, any state) forces the following; err clears only on reset:
  - FSM to IDLE; all counters to 0.
  - All outputs 0, except conv_kernel_00 = kernel[0].
  - Kernel registers to 32'h3f800000 (1.0).
- FSM states and transitions:
  - IDLE: start=1 -> ISSUE, with ch=0, rd_idx=0, out_idx=0.
  - ISSUE: each cycle with hold=0 asserts mem_rd_en with mem_addr = ch*T + rd_idx, then increments rd_idx. After the read with rd_idx = T-1 -> DRAIN.
  - DRAIN: no reads issued; wait until out_idx reaches T. Then ch = CH-1 -> DONE; otherwise ch+1 and rd_idx=0 -> ISSUE. out_idx resets when the channel changes.
  - DONE: done=1 for one cycle -> IDLE.
- Datapath timing:
  - conv_valid_in is mem_rd_en registered one cycle.
  - conv_pxl_in = mem_rd_data (combinational pass-through).
  - A read issued in the last ISSUE cycle still produces its conv_valid_in in the first DRAIN cycle.
- Kernel selection: conv_kernel_00 = kernel[ch], registered, and stable for the entire channel including drain. It changes only on the ISSUE entry edge.
- Kernel writes:
  - Accepted only in IDLE; ignored while busy.
  - kw_sel >= CH is ignored.
- Result forwarding:
  - When conv_valid_out=1 in ISSUE or DRAIN with out_idx < T: out_valid, out_pxl, out_ch are registered (1-cycle latency) and out_idx increments.
  - out_last=1 when ch=CH-1 and out_idx=T-1.
- Error conditions (err set, sample dropped, out_valid stays 0):
  - conv_valid_out in IDLE or DONE.
  - conv_valid_out with out_idx = T.
- start handling: ignored unless in IDLE; a start coinciding with done is ignored.
- hold: has no effect on drain or forwarding, and is ignored outside ISSUE.
- busy = state is not IDLE.
- Throughput without hold: CH*(T + drain) cycles, where drain = conv_11 latency + 1.

Decomposition:
- Package conv_sched_pkg contains:
  - FSM state encoding (IDLE, ISSUE, DRAIN, DONE).
  - FP_ONE = 32'h3f800000.
  - clog2-derived widths for rd_idx/out_idx.
- Sub-module conv_kernel_bank: CH x DATA_WIDTH register file with IDLE-gated write and registered read by ch.

Test Plan (D=4, T=16, CH=3, bench conv_11 model = identity with 2-cycle latency, memory word = address):
- Reset, no writes, start -> 48 reads at addresses 0..47; conv_kernel_00 = 32'h3f800000 for all channels; 48 out_valid with out_pxl 0..47; out_ch 0/1/2 in blocks of 16; out_last on pxl 47; done once; err=0.
- Write kernels 3f800000/40000000/40400000, start -> conv_kernel_00 changes only after the 16th output of each channel; no conv_valid_in during DRAIN beyond the trailing read.
- hold high for 5 cycles mid-channel-1 -> mem_rd_en low during those cycles; addresses continue from the paused index without skip or repeat; total outputs still 48.
- kw_en while busy, and start while busy -> kernels and sequence unchanged.
- Inject conv_valid_out in IDLE -> err=1, out_valid=0; err persists until reset.
- Assert reset during channel 1 -> all outputs 0 asynchronously, kernels back to 1.0; a following start restarts at address 0.
